// File: rtl/pattern_sequencer.sv
// Frame-synchronous test pattern scheduler: picks the active pattern index at vsync
// boundaries (host set, manual next, or auto dwell) and checks active lines per frame.
module pattern_sequencer #(
   parameter int NUM_PATTERNS       = 8,
   parameter int FRAMES_PER_PATTERN = 120,
   parameter int VACTIVE            = 720,
   parameter int FRAME_COUNT_BITS   = 16,
   localparam int PAT_BITS          = $clog2(NUM_PATTERNS)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        vsync_in,
   input  logic                        de_in,
   input  logic                        auto_en,
   input  logic                        next_req,
   input  logic                        set_valid,
   input  logic [PAT_BITS-1:0]         set_pattern,
   output logic                        set_ready,
   input  logic                        error_clear,
   output logic [PAT_BITS-1:0]         pattern_sel,
   output logic                        frame_start,
   output logic                        pattern_changed,
   output logic [FRAME_COUNT_BITS-1:0] frame_count,
   output logic                        timing_error
);

   localparam int DWELL_BITS = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
   localparam int LINE_BITS  = $clog2(VACTIVE + 2);

   localparam logic [PAT_BITS-1:0]   LAST_PAT   = PAT_BITS'(NUM_PATTERNS - 1);
   localparam logic [DWELL_BITS-1:0] DWELL_LAST = DWELL_BITS'(FRAMES_PER_PATTERN - 1);
   localparam logic [LINE_BITS-1:0]  LINE_EXP   = LINE_BITS'(VACTIVE);
   localparam logic [LINE_BITS-1:0]  LINE_SAT   = LINE_BITS'(VACTIVE + 1);

   typedef enum logic [1:0] {
      S_SYNC_WAIT,
      S_RUN,
      S_PENDING
   } state_t;

   state_t                      state_q, state_d;
   logic                        vsync_q, de_q;
   logic [PAT_BITS-1:0]         sel_q, sel_d;
   logic [PAT_BITS-1:0]         pend_q, pend_d;
   logic                        next_pend_q, next_pend_d;
   logic [DWELL_BITS-1:0]       dwell_q, dwell_d;
   logic [LINE_BITS-1:0]        line_q, line_d;
   logic [FRAME_COUNT_BITS-1:0] fcount_q, fcount_d;
   logic                        fstart_q, fstart_d;
   logic                        changed_q, changed_d;
   logic                        err_q, err_d;

   logic                        boundary;
   logic                        de_rise;
   logic                        active;
   logic                        applied;
   logic [PAT_BITS-1:0]         sel_inc;
   logic [PAT_BITS-1:0]         set_clamped;

   assign boundary = vsync_in & ~vsync_q;
   assign de_rise  = de_in & ~de_q;
   assign active   = (state_q == S_RUN) || (state_q == S_PENDING);
   assign sel_inc  = (sel_q == LAST_PAT) ? '0 : sel_q + PAT_BITS'(1);

   // Out-of-range requests only exist when NUM_PATTERNS is not a power of two.
   generate
      if ((2 ** PAT_BITS) > NUM_PATTERNS) begin : g_clamp
         assign set_clamped = (set_pattern > LAST_PAT) ? LAST_PAT : set_pattern;
      end else begin : g_noclamp
         assign set_clamped = set_pattern;
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      pend_d      = pend_q;
      next_pend_d = next_pend_q | next_req;
      dwell_d     = dwell_q;
      line_d      = line_q;
      fcount_d    = fcount_q;
      fstart_d    = 1'b0;
      changed_d   = 1'b0;
      err_d       = err_q;
      applied     = 1'b0;

      if (error_clear) begin
         err_d = 1'b0;
      end
      if (de_rise && (line_q != LINE_SAT)) begin
         line_d = line_q + LINE_BITS'(1);
      end

      case (state_q)
         S_SYNC_WAIT: begin
            if (boundary) state_d = S_RUN;
         end
         S_RUN: begin
            // A capture on a boundary cycle lands in PENDING and waits a full frame.
            if (set_valid) begin
               state_d = S_PENDING;
               pend_d  = set_clamped;
            end
         end
         S_PENDING: begin
            if (boundary) state_d = S_RUN;
         end
         default: state_d = S_SYNC_WAIT;
      endcase

      if (boundary) begin
         line_d      = '0;
         next_pend_d = 1'b0;
         if (active) begin
            fstart_d = 1'b1;
            fcount_d = fcount_q + FRAME_COUNT_BITS'(1);
            if (state_q == S_PENDING) begin
               sel_d   = pend_q;
               applied = 1'b1;
            end else if (next_pend_q || next_req) begin
               sel_d   = sel_inc;
               applied = 1'b1;
            end else if (auto_en && (dwell_q == DWELL_LAST)) begin
               sel_d   = sel_inc;
               applied = 1'b1;
            end
            if (applied) begin
               dwell_d = '0;
            end else if (auto_en) begin
               dwell_d = dwell_q + DWELL_BITS'(1);
            end
            changed_d = (sel_d != sel_q);
            if (line_q != LINE_EXP) begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_SYNC_WAIT;
         vsync_q     <= 1'b0;
         de_q        <= 1'b0;
         sel_q       <= '0;
         pend_q      <= '0;
         next_pend_q <= 1'b0;
         dwell_q     <= '0;
         line_q      <= '0;
         fcount_q    <= '0;
         fstart_q    <= 1'b0;
         changed_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         vsync_q     <= vsync_in;
         de_q        <= de_in;
         sel_q       <= sel_d;
         pend_q      <= pend_d;
         next_pend_q <= next_pend_d;
         dwell_q     <= dwell_d;
         line_q      <= line_d;
         fcount_q    <= fcount_d;
         fstart_q    <= fstart_d;
         changed_q   <= changed_d;
         err_q       <= err_d;
      end
   end

   assign set_ready       = (state_q == S_RUN);
   assign pattern_sel     = sel_q;
   assign frame_start     = fstart_q;
   assign pattern_changed = changed_q;
   assign frame_count     = fcount_q;
   assign timing_error    = err_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios with literal expectations, then
// randomized frames checked every cycle against an event-level reference model.
module tb_pattern_sequencer;

   localparam int N   = 6;
   localparam int F   = 3;
   localparam int V   = 16;
   localparam int FCB = 4;
   localparam int PB  = $clog2(N);

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           vsync_in = 1'b0;
   logic           de_in = 1'b0;
   logic           auto_en = 1'b0;
   logic           next_req = 1'b0;
   logic           set_valid = 1'b0;
   logic [PB-1:0]  set_pattern = '0;
   logic           set_ready;
   logic           error_clear = 1'b0;
   logic [PB-1:0]  pattern_sel;
   logic           frame_start;
   logic           pattern_changed;
   logic [FCB-1:0] frame_count;
   logic           timing_error;

   pattern_sequencer #(
      .NUM_PATTERNS(N),
      .FRAMES_PER_PATTERN(F),
      .VACTIVE(V),
      .FRAME_COUNT_BITS(FCB)
   ) dut (
      .clock(clock),
      .reset(reset),
      .vsync_in(vsync_in),
      .de_in(de_in),
      .auto_en(auto_en),
      .next_req(next_req),
      .set_valid(set_valid),
      .set_pattern(set_pattern),
      .set_ready(set_ready),
      .error_clear(error_clear),
      .pattern_sel(pattern_sel),
      .frame_start(frame_start),
      .pattern_changed(pattern_changed),
      .frame_count(frame_count),
      .timing_error(timing_error)
   );

   always #5 clock = ~clock;

   int n_pass = 0;
   int n_total = 0;
   int chg_seen = 0;
   bit rand_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference model: tracks frames and requests as events, not as a state machine.
   bit m_ok = 1'b0;
   bit m_synced, m_pending, m_next, m_fs, m_chg, m_err, m_vs_prev, m_de_prev;
   int m_sel, m_pend_val, m_dwell, m_lines, m_count;

   task automatic model_step();
      bit b, dr, ready_now, applied;
      int old;
      if (reset) begin
         m_synced = 0; m_pending = 0; m_next = 0; m_fs = 0; m_chg = 0; m_err = 0;
         m_vs_prev = 0; m_de_prev = 0;
         m_sel = 0; m_pend_val = 0; m_dwell = 0; m_lines = 0; m_count = 0;
         m_ok = 1;
         return;
      end
      b = vsync_in && !m_vs_prev;
      dr = de_in && !m_de_prev;
      m_vs_prev = vsync_in;
      m_de_prev = de_in;
      ready_now = m_synced && !m_pending;
      m_fs = 0;
      m_chg = 0;
      if (error_clear) m_err = 0;
      if (b) begin
         if (m_synced) begin
            m_fs = 1;
            m_count = (m_count + 1) % (1 << FCB);
            old = m_sel;
            applied = 1;
            if (m_pending) begin
               m_sel = m_pend_val;
               m_pending = 0;
            end else if (m_next || next_req) begin
               m_sel = (m_sel + 1) % N;
            end else if (auto_en && m_dwell == F - 1) begin
               m_sel = (m_sel + 1) % N;
            end else begin
               applied = 0;
            end
            if (applied) m_dwell = 0;
            else if (auto_en) m_dwell++;
            m_chg = (m_sel != old);
            if (m_lines != V) m_err = 1;
         end else begin
            m_synced = 1;
         end
         m_lines = 0;
         m_next = 0;
      end else begin
         if (dr && m_lines < V + 1) m_lines++;
         if (next_req) m_next = 1;
      end
      if (ready_now && set_valid) begin
         m_pending = 1;
         m_pend_val = (int'(set_pattern) >= N) ? N - 1 : int'(set_pattern);
      end
   endtask

   initial begin
      forever begin
         @(posedge clock);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (m_ok) begin
            chk("pattern_sel", 32'(pattern_sel), 32'(m_sel));
            chk("frame_start", 32'(frame_start), 32'(m_fs));
            chk("pattern_changed", 32'(pattern_changed), 32'(m_chg));
            chk("frame_count", 32'(frame_count), 32'(m_count));
            chk("timing_error", 32'(timing_error), 32'(m_err));
            chk("set_ready", 32'(set_ready), 32'(m_synced && !m_pending));
         end
         if (pattern_changed === 1'b1) chg_seen++;
      end
   end

   // Random request traffic, active only during the randomized phase.
   initial begin
      forever begin
         @(negedge clock);
         if (rand_en) begin
            next_req    = ($urandom_range(0, 39) == 0);
            set_valid   = ($urandom_range(0, 29) == 0);
            set_pattern = PB'($urandom_range(0, 7));
            error_clear = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic vs_edge();
      vsync_in = 1'b1;
      tick();
      vsync_in = 1'b0;
      tick();
   endtask

   task automatic lines(input int n);
      for (int l = 0; l < n; l++) begin
         de_in = 1'b1;
         tick();
         de_in = 1'b0;
         tick();
      end
   endtask

   task automatic host_set(input int v);
      set_valid = 1'b1;
      set_pattern = PB'(v);
      tick();
      set_valid = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      chk("reset_sel", 32'(pattern_sel), 0);
      chk("reset_ready", 32'(set_ready), 0);
      reset = 1'b0;

      // Auto-advance after the dwell time.
      auto_en = 1'b1;
      chg_seen = 0;
      for (int f = 0; f < 4; f++) begin
         vs_edge();
         if (f < 3) lines(V);
      end
      chk("auto_sel", 32'(pattern_sel), 1);
      chk("auto_count", 32'(frame_count), 3);
      chk("auto_err", 32'(timing_error), 0);
      chk("auto_chg_pulses", 32'(chg_seen), 1);
      lines(V);

      // Host set, then three next pulses in one frame advance once, wrapping.
      auto_en = 1'b0;
      lines(0);
      host_set(5);
      vs_edge();
      chk("host_set_sel", 32'(pattern_sel), 5);
      lines(4);
      for (int k = 0; k < 3; k++) begin
         next_req = 1'b1;
         tick();
         next_req = 1'b0;
         tick();
      end
      lines(V - 4);
      vs_edge();
      chk("next_wrap_sel", 32'(pattern_sel), 0);

      // Set plus next in the same frame: set wins, next is discarded.
      lines(4);
      set_valid = 1'b1;
      set_pattern = PB'(5);
      next_req = 1'b1;
      tick();
      set_valid = 1'b0;
      next_req = 1'b0;
      chk("pending_ready", 32'(set_ready), 0);
      lines(V - 4);
      vsync_in = 1'b1;
      tick();
      chk("set_apply_sel", 32'(pattern_sel), 5);
      chk("ready_after", 32'(set_ready), 1);
      vsync_in = 1'b0;
      tick();
      lines(V);
      vs_edge();
      chk("next_dropped_sel", 32'(pattern_sel), 5);

      // Out-of-range request clamps to the last pattern.
      host_set(2);
      lines(V);
      vs_edge();
      chk("set2_sel", 32'(pattern_sel), 2);
      host_set(7);
      lines(V);
      vs_edge();
      chk("clamp_sel", 32'(pattern_sel), 5);

      // Short frame, clear, and clear coinciding with a mismatched boundary.
      lines(V - 1);
      vs_edge();
      chk("short_err", 32'(timing_error), 1);
      error_clear = 1'b1;
      tick();
      error_clear = 1'b0;
      chk("cleared_err", 32'(timing_error), 0);
      lines(V - 2);
      vsync_in = 1'b1;
      error_clear = 1'b1;
      tick();
      error_clear = 1'b0;
      vsync_in = 1'b0;
      chk("set_wins_err", 32'(timing_error), 1);
      error_clear = 1'b1;
      tick();
      error_clear = 1'b0;
      tick();

      // Reset while a request is pending.
      lines(V);
      host_set(3);
      reset = 1'b1;
      tick();
      tick();
      chk("rst_sel", 32'(pattern_sel), 0);
      chk("rst_count", 32'(frame_count), 0);
      chk("rst_ready", 32'(set_ready), 0);
      chk("rst_err", 32'(timing_error), 0);
      reset = 1'b0;
      lines(V);
      chk("rst_wait_ready", 32'(set_ready), 0);
      vs_edge();
      chk("resync_ready", 32'(set_ready), 1);
      chk("resync_count", 32'(frame_count), 0);
      lines(V);
      vs_edge();
      chk("discard_sel", 32'(pattern_sel), 0);
      chk("discard_count", 32'(frame_count), 1);

      // Randomized frames against the reference model.
      rand_en = 1'b1;
      auto_en = 1'b1;
      for (int f = 0; f < 50; f++) begin
         int nl;
         nl = ($urandom_range(0, 7) == 0) ? V - 2 + $urandom_range(0, 4) : V;
         vsync_in = 1'b1;
         repeat ($urandom_range(1, 3)) tick();
         vsync_in = 1'b0;
         tick();
         lines(nl);
         repeat ($urandom_range(0, 3)) tick();
         if (f == 30) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
      end
      rand_en = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
